if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the architectural fetch PC and issues one word fetch at a time to instruction memory over a req/ready and rvalid handshake. It buffers the returned word and presents PC, instruction and unvalid_PC to IF/ID. It also handles stalls from the hazard unit and branch/jump redirects, squashing wrong-path fetches.

Parameters:
PC_WIDTH, 8, width of PC and imem address (byte address)
INST_WIDTH, 32, instruction word width
RESET_PC, 8'h00, fetch address after reset
PC_STEP, 4, sequential PC increment

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hazard unit: hold presented instruction, no advance
redirect  in  1  taken branch/jump resolved downstream, one-cycle pulse
redirect_PC  in  PC_WIDTH  target address, valid with redirect
imem_req  out  1  fetch request
imem_addr  out  PC_WIDTH  fetch address, stable while imem_req=1 and no redirect
imem_ready  in  1  memory accepts request this cycle (imem_req & imem_ready)
imem_rvalid  in  1  read data valid; earliest the cycle after acceptance
imem_rdata  in  INST_WIDTH  read data
PC  out  PC_WIDTH  address of presented instruction (to IF/ID PC)
instruction  out  INST_WIDTH  presented instruction (to IF/ID instruction)
unvalid_PC  out  1  1 = no valid instruction; IF/ID loads bubble

Behaviour:
- Reset (async, rst_n=0): state=REQ, fetch_pc=RESET_PC, buf_valid=0, PC=0, instruction=0, unvalid_PC=1, imem_req=0. Outputs hold these values until rst_n deasserts.
- Internal state: fetch_pc, 3-state FSM {REQ, WAIT, KILL}, and a one-entry output buffer (PC, instruction, buf_valid).
- unvalid_PC = !buf_valid | redirect. This is combinational, so the redirect cycle flushes IF/ID in the same edge.
- Consume: the buffer is consumed at an edge where buf_valid=1, stall=0 and redirect=0. On consume, buf_valid clears unless refilled in the same edge.
- REQ:
  - imem_req = !buf_valid | !stall.
  - imem_addr = fetch_pc.
  - On accept with no redirect: go to WAIT and latch fetch_pc as the in-flight address.
- WAIT:
  - imem_req=0.
  - On imem_rvalid: buffer <= {in-flight addr, imem_rdata}, buf_valid=1, fetch_pc += PC_STEP, go to REQ.
  - The buffer is always free here, because REQ only issued once it was free or being consumed.
- KILL: imem_req=0. The next imem_rvalid is discarded, then go to REQ.
- imem_rvalid is ignored in REQ.
- Redirect has highest priority, in any state:
  - fetch_pc <= redirect_PC and buf_valid <= 0.
  - REQ with a same-cycle accept goes to KILL, because the stale request is already in flight. REQ without accept stays in REQ, and imem_addr may change to the new target.
  - WAIT with no rvalid this cycle goes to KILL. WAIT with rvalid this cycle drops the data and goes to REQ.
  - KILL with rvalid this cycle goes to REQ. KILL without rvalid stays in KILL.
- Stall: buffer contents and unvalid_PC are held. A fetch already in WAIT completes only if the buffer is empty; otherwise no new request is issued.
- PC arithmetic is modulo 2^PC_WIDTH: 8'hFC + 4 -> 8'h00. No alignment check.
- Throughput: one instruction per 2 cycles with a 1-cycle memory. This is intentional; there is a single outstanding request.
- PC and instruction outputs hold their last values while unvalid_PC=1.
- Reset mid-fetch: all state clears. A late rvalid arriving in REQ after reset is ignored.

Test Plan:
- Reset release, memory always ready with 1-cycle rvalid returning 32'h1000_0000+addr -> imem_addr sequence 00,04,08. Presented PC 00,04,08 with matching words. unvalid_PC=1 on alternate cycles.
- PC wrap: redirect to 8'hFC, then sequential -> fetch addresses FC, 00, 04.
- stall=1 for 5 cycles while buffer valid at PC=08 -> PC/instruction/unvalid_PC stable, imem_req=0 after the pending fetch. On release, next fetch address is 0C.
- redirect (target 8'h40) in the same cycle as imem_ready -> KILL; the returned word for the old addr is discarded, next imem_addr=40, and unvalid_PC=1 in the redirect cycle.
- redirect to 8'h80 coincident with imem_rvalid in WAIT -> data dropped, buffer invalid, next request addr=80.
- Memory delays imem_ready 3 cycles, then imem_rvalid 4 cycles after accept -> imem_addr stable throughout and unvalid_PC=1 until data arrives. Assert rst_n=0 mid-WAIT -> outputs immediately PC=0, instruction=0, unvalid_PC=1.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch bus: one request at a time via a req/ready
// handshake, with the read data returned later on rvalid.
interface if_fetch_stage_if #(
  parameter int PC_WIDTH   = 8,
  parameter int INST_WIDTH = 32
) ();
  logic                  imem_req;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic                  imem_ready;
  logic                  imem_rvalid;
  logic [INST_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID register. Owns the fetch PC,
// keeps a single request outstanding to instruction memory, buffers the
// returned word and squashes wrong-path fetches on redirect.
module if_fetch_stage #(
  parameter int                  PC_WIDTH   = 8,
  parameter int                  INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_PC,
  if_fetch_stage_if.master      imem,
  output logic [PC_WIDTH-1:0]   PC,
  output logic [INST_WIDTH-1:0] instruction,
  output logic                  unvalid_PC
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_KILL} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PC_WIDTH-1:0]   r_fetch_pc;
  logic [PC_WIDTH-1:0]   r_inflight_pc;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [INST_WIDTH-1:0] r_instr;
  logic                  r_buf_valid;
  logic                  w_req;
  logic                  w_accept;
  logic                  w_fill;
  logic                  w_consume;

  // Sequential PC step; wraps modulo 2^PC_WIDTH with no alignment check.
  function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
    return pc + PC_WIDTH'(PC_STEP);
  endfunction

  // Next state and request; redirect overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_fill      = 1'b0;
    case (r_state)
      S_REQ: begin
        // Request only when the buffer is free or is being taken this edge;
        // held low while reset is asserted.
        w_req = rst_n & (!r_buf_valid | !stall);
        if (w_req && imem.imem_ready) begin
          // A request accepted during a redirect is already wrong-path.
          w_state_nxt = redirect ? S_KILL : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          w_state_nxt = S_REQ;
          w_fill      = !redirect;
        end else if (redirect) begin
          w_state_nxt = S_KILL;
        end
      end
      S_KILL: begin
        // Swallow the one stale response still owed by memory.
        if (imem.imem_rvalid) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  assign w_accept       = w_req & imem.imem_ready;
  assign w_consume      = r_buf_valid & !stall & !redirect;
  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_fetch_pc;

  // FSM state, fetch PC and the address of the request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_REQ;
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (redirect) begin
        r_fetch_pc <= redirect_PC;
      end else if (w_fill) begin
        r_fetch_pc <= pc_inc(r_fetch_pc);
      end
      if (w_accept) r_inflight_pc <= r_fetch_pc;
    end
  end

  // One-entry output buffer presented to IF/ID; contents hold when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_valid <= 1'b0;
      r_pc        <= '0;
      r_instr     <= '0;
    end else if (w_fill) begin
      r_buf_valid <= 1'b1;
      r_pc        <= r_inflight_pc;
      r_instr     <= imem.imem_rdata;
    end else if (redirect || w_consume) begin
      r_buf_valid <= 1'b0;
    end
  end

  // Redirect bubbles IF/ID combinationally in the same cycle.
  assign unvalid_PC  = !r_buf_valid | redirect;
  assign PC          = r_pc;
  assign instruction = r_instr;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed stimulus with a scoreboard of expected
// fetch addresses and consumed (PC, instruction) pairs, plus a memory model
// with configurable ready delay and read latency.
module tb_if_fetch_stage;
  localparam int PW = 8;
  localparam int IW = 32;

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic          redirect;
  logic [PW-1:0] redirect_PC;
  logic [PW-1:0] PC;
  logic [IW-1:0] instruction;
  logic          unvalid_PC;

  if_fetch_stage_if #(.PC_WIDTH(PW), .INST_WIDTH(IW)) bus ();

  if_fetch_stage #(
    .PC_WIDTH(PW), .INST_WIDTH(IW), .RESET_PC(8'h00), .PC_STEP(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .redirect(redirect),
    .redirect_PC(redirect_PC),
    .imem(bus.master),
    .PC(PC),
    .instruction(instruction),
    .unvalid_PC(unvalid_PC)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [PW-1:0]    q_addr[$];
  logic [PW+IW-1:0] q_out[$];

  // Memory model state
  bit            m_pend;
  logic [PW-1:0] m_addr;
  int            m_cnt;
  int            m_rdy_cnt;
  int            cfg_rdy_delay = 0;
  int            cfg_lat       = 1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_out(input logic [PW-1:0] pc, input logic [IW-1:0] inst);
    q_out.push_back({pc, inst});
  endtask

  // Wait (sampling at negedge+2) until the buffer presents the given PC.
  task automatic wait_pres(input logic [PW-1:0] pc);
    int n = 0;
    while (!(!unvalid_PC && PC == pc)) begin
      @(negedge clk); #2;
      n++;
      if (n > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout waiting for PC %0h, got PC %0h unvalid %0b", pc, PC, unvalid_PC);
        return;
      end
    end
  endtask

  // Memory driver: responds just after negedge, once the DUT has settled.
  initial begin
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    m_rdy_cnt       = 0;
    forever begin
      @(negedge clk); #1;
      bus.imem_rvalid = m_pend && (m_cnt == 1);
      bus.imem_rdata  = bus.imem_rvalid ? (32'h1000_0000 + 32'(m_addr)) : 32'hDEAD_BEEF;
      if (bus.imem_req && !m_pend) begin
        bus.imem_ready = (m_rdy_cnt >= cfg_rdy_delay);
        m_rdy_cnt++;
      end else begin
        bus.imem_ready = 1'b0;
        m_rdy_cnt      = 0;
      end
    end
  end

  // Monitor: checks handshakes just before each posedge, then updates memory.
  initial begin
    logic [PW-1:0]    ea;
    logic [PW+IW-1:0] eo;
    m_pend = 1'b0;
    m_addr = '0;
    m_cnt  = 0;
    forever begin
      @(negedge clk); #4;
      if (bus.imem_req && bus.imem_ready) begin
        if (q_addr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_fetch: addr %0h with no fetch expected", bus.imem_addr);
        end else begin
          ea = q_addr.pop_front();
          chk("fetch_addr", 64'(bus.imem_addr), 64'(ea));
        end
      end
      if (rst_n && !unvalid_PC && !stall && !redirect) begin
        if (q_out.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_present: PC %0h inst %0h with none expected", PC, instruction);
        end else begin
          eo = q_out.pop_front();
          chk("present_pc_inst", 64'({PC, instruction}), 64'(eo));
        end
      end
      if (bus.imem_rvalid) m_pend = 1'b0;
      else if (m_pend) m_cnt--;
      if (bus.imem_req && bus.imem_ready) begin
        m_pend = 1'b1;
        m_addr = bus.imem_addr;
        m_cnt  = cfg_lat;
      end
    end
  end

  // Directed stimulus
  initial begin
    int n;
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_PC = '0;

    foreach (q_addr[i]) q_addr.delete(i);
    q_addr = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h40, 8'h44, 8'hFC,
               8'h00, 8'h04, 8'h08, 8'h80, 8'h84, 8'h88, 8'h00, 8'h04};
    push_out(8'h00, 32'h1000_0000);
    push_out(8'h04, 32'h1000_0004);
    push_out(8'h08, 32'h1000_0008);
    push_out(8'h40, 32'h1000_0040);
    push_out(8'hFC, 32'h1000_00FC);
    push_out(8'h00, 32'h1000_0000);
    push_out(8'h04, 32'h1000_0004);
    push_out(8'h80, 32'h1000_0080);
    push_out(8'h84, 32'h1000_0084);
    push_out(8'h00, 32'h1000_0000);

    repeat (2) @(negedge clk);
    #2;
    chk("reset_pc", 64'(PC), 64'h0);
    chk("reset_inst", 64'(instruction), 64'h0);
    chk("reset_unvalid", 64'(unvalid_PC), 64'h1);
    chk("reset_req", 64'(bus.imem_req), 64'h0);
    rst_n = 1'b1;

    // Hold the buffer at PC 08 for five cycles.
    wait_pres(8'h08);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      chk("stall_pc", 64'(PC), 64'h08);
      chk("stall_inst", 64'(instruction), 64'h1000_0008);
      chk("stall_unvalid", 64'(unvalid_PC), 64'h0);
      chk("stall_req", 64'(bus.imem_req), 64'h0);
    end
    stall = 1'b0;
    #1;
    chk("release_addr", 64'(bus.imem_addr), 64'h0C);

    // Redirect to 40 in the same cycle the fetch of 10 is accepted.
    wait_pres(8'h0C);
    redirect    = 1'b1;
    redirect_PC = 8'h40;
    #1;
    chk("redir_unvalid", 64'(unvalid_PC), 64'h1);
    chk("redir_accept", 64'(bus.imem_req & bus.imem_ready), 64'h1);
    @(negedge clk); #2;
    redirect = 1'b0;

    // Redirect to FC while stalled (no accept), then wrap FC -> 00 -> 04.
    wait_pres(8'h44);
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_PC = 8'hFC;
    @(negedge clk); #2;
    stall    = 1'b0;
    redirect = 1'b0;
    chk("wrap_target_addr", 64'(bus.imem_addr), 64'hFC);
    chk("wrap_unvalid", 64'(unvalid_PC), 64'h1);

    // Redirect to 80 coincident with rvalid while in WAIT.
    wait_pres(8'h04);
    @(negedge clk); #2;
    chk("wait_req_low", 64'(bus.imem_req), 64'h0);
    chk("wait_rvalid", 64'(bus.imem_rvalid), 64'h1);
    redirect    = 1'b1;
    redirect_PC = 8'h80;
    @(negedge clk); #2;
    redirect = 1'b0;
    chk("drop_unvalid", 64'(unvalid_PC), 64'h1);
    chk("drop_next_addr", 64'(bus.imem_addr), 64'h80);

    // Slow memory: delayed ready and long read latency.
    wait_pres(8'h80);
    stall         = 1'b1;
    cfg_rdy_delay = 3;
    cfg_lat       = 4;
    @(negedge clk); #2;
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      chk("slow_addr", 64'(bus.imem_addr), 64'h84);
      chk("slow_unvalid", 64'(unvalid_PC), 64'h1);
    end
    wait_pres(8'h84);
    n = 0;
    while (bus.imem_req) begin
      @(negedge clk); #2;
      n++;
      if (n > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout waiting for fetch of 88 to be accepted");
        break;
      end
    end

    // Reset in the middle of WAIT.
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_pc", 64'(PC), 64'h0);
    chk("midreset_inst", 64'(instruction), 64'h0);
    chk("midreset_unvalid", 64'(unvalid_PC), 64'h1);
    chk("midreset_req", 64'(bus.imem_req), 64'h0);
    cfg_rdy_delay = 0;
    cfg_lat       = 1;
    @(negedge clk); #2;
    rst_n = 1'b1;

    // The late rvalid for 88 lands in REQ and must be ignored.
    wait_pres(8'h04);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("addr_queue_drained", 64'(q_addr.size()), 64'h0);
    chk("out_queue_drained", 64'(q_out.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
